// File: rtl/mm_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, TX/RX state encodings and the baud divisor clamp.
package mm_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_BAUD   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_LOOPBACK   = 15;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A divisor below 2 would leave no room for the RX half-bit wait.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/mm_uart_if.sv
// CPU external data bus as seen by a memory-mapped responder.
interface mm_uart_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mm_we;
  logic        mm_re;
  logic [15:0] rdata;

  modport master (output addr, wdata, mm_we, mm_re, input rdata);
  modport slave  (input addr, wdata, mm_we, mm_re, output rdata);
endinterface

// File: rtl/mm_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a pop on a full
// FIFO frees the slot for a push in the same cycle.
module mm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mm_uart_periph.sv
// Memory-mapped 8N1 UART: 4-word register window, TX/RX FIFOs, TX and RX FSMs.
// Optional MM_UART_LOOPBACK_EN adds STATUS[15] to route internal tx into RX.
//
// state    | meaning
// TX_IDLE  | line high, pops the TX FIFO when it holds a byte
// TX_START | driving the start bit (low)
// TX_DATA  | driving data bits LSB first
// TX_STOP  | driving the stop bit; chains straight into the next byte if queued
// RX_IDLE  | waiting for a 1->0 transition on the RX input
// RX_START | half-bit wait, then recheck the line is still low
// RX_DATA  | sampling 8 data bits one bit period apart
// RX_STOP  | sampling the stop bit; push, overrun or frame error
module mm_uart_periph
  import mm_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic      clk,
  input  logic      rst_n,
  mm_uart_if.slave  bus,
  output logic      tx,
  input  logic      rx
);

  logic        sel, wr_acc, rd_acc;
  logic [1:0]  off;
  logic        tx_push, rx_pop, status_wr, baud_wr;
  logic [15:0] baud_div, n_eff;
  logic        rx_overrun, frame_err, loopback;
  logic [15:0] status_word;

  logic [7:0]  tx_dout, rx_dout;
  logic        tx_full, tx_empty, rx_full, rx_empty;

  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic        tx_nxt, tx_pop;

  rx_state_t   rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic        rx_meta, rx_sync, rx_prev, rx_in;
  logic        rx_push, overrun_set, ferr_set;

  assign sel       = (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign off       = bus.addr[1:0];
  assign wr_acc    = bus.mm_we && sel;
  assign rd_acc    = bus.mm_re && sel;
  assign tx_push   = wr_acc && (off == OFF_TXDATA);
  assign status_wr = wr_acc && (off == OFF_STATUS);
  assign baud_wr   = wr_acc && (off == OFF_BAUD);
  assign rx_pop    = rd_acc && (off == OFF_RXDATA);
  assign n_eff     = eff_div(baud_div);

  mm_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .din(bus.wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  mm_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div   <= DIV_RESET;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (baud_wr) baud_div <= bus.wdata;
      // Clear first so a same-cycle set wins.
      if (status_wr && bus.wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
      if (overrun_set) rx_overrun <= 1'b1;
      if (status_wr && bus.wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

`ifdef MM_UART_LOOPBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         loopback <= 1'b0;
    else if (status_wr) loopback <= bus.wdata[ST_LOOPBACK];
  end
`else
  assign loopback = 1'b0;
`endif

  always_comb begin
    status_word                = '0;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_EMPTY]   = tx_empty;
    status_word[ST_RX_AVAIL]   = !rx_empty;
    status_word[ST_RX_OVERRUN] = rx_overrun;
    status_word[ST_TX_BUSY]    = (tx_state != TX_IDLE);
    status_word[ST_FRAME_ERR]  = frame_err;
    status_word[ST_LOOPBACK]   = loopback;
  end

  always_comb begin
    bus.rdata = '0;
    if (rd_acc) begin
      case (off)
        OFF_RXDATA: bus.rdata = {8'h00, rx_empty ? 8'h00 : rx_dout};
        OFF_STATUS: bus.rdata = status_word;
        OFF_BAUD:   bus.rdata = baud_div;
        default:    bus.rdata = '0;
      endcase
    end
  end

  // TX: every state bit is one down-count from N-1 to 0; N is re-read per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_shift <= tx_shift_nxt;
      tx_bit   <= tx_bit_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_shift_nxt = tx_shift;
    tx_bit_nxt   = tx_bit;
    tx_nxt       = tx;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = tx_dout;
          tx_nxt       = 1'b0;
          tx_cnt_nxt   = n_eff - 16'd1;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt != 16'd0) tx_cnt_nxt = tx_cnt - 16'd1;
        else begin
          tx_nxt       = tx_shift[0];
          tx_bit_nxt   = 3'd0;
          tx_cnt_nxt   = n_eff - 16'd1;
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt != 16'd0) tx_cnt_nxt = tx_cnt - 16'd1;
        else begin
          tx_cnt_nxt = n_eff - 16'd1;
          if (tx_bit == 3'd7) begin
            tx_nxt       = 1'b1;
            tx_state_nxt = TX_STOP;
          end else begin
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_nxt       = tx_shift[1];
            tx_bit_nxt   = tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != 16'd0) tx_cnt_nxt = tx_cnt - 16'd1;
        else if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = tx_dout;
          tx_nxt       = 1'b0;
          tx_cnt_nxt   = n_eff - 16'd1;
          tx_state_nxt = TX_START;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
    endcase
  end

  // RX: loopback takes the registered tx directly, so no synchroniser needed.
  assign rx_in = loopback ? tx : rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_in;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_shift <= rx_shift_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_shift_nxt = rx_shift;
    rx_bit_nxt   = rx_bit;
    rx_push      = 1'b0;
    overrun_set  = 1'b0;
    ferr_set     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_in) begin
          rx_cnt_nxt   = (n_eff >> 1) - 16'd1;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) rx_cnt_nxt = rx_cnt - 16'd1;
        else if (!rx_in) begin
          rx_cnt_nxt   = n_eff - 16'd1;
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = RX_DATA;
        end else begin
          rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) rx_cnt_nxt = rx_cnt - 16'd1;
        else begin
          rx_shift_nxt = {rx_in, rx_shift[7:1]};
          rx_cnt_nxt   = n_eff - 16'd1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) rx_cnt_nxt = rx_cnt - 16'd1;
        else begin
          rx_state_nxt = RX_IDLE;
          if (!rx_in)                  ferr_set    = 1'b1;
          else if (rx_full && !rx_pop) overrun_set = 1'b1;
          else                         rx_push     = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mm_uart_periph.sv
// Directed/randomised bench for mm_uart_periph: serial frames are decoded and
// generated at bit level and compared against queue-based reference models.
module tb_mm_uart_periph;

  localparam logic [15:0] BASE   = 16'hC000;
  localparam logic [15:0] A_TX   = BASE;
  localparam logic [15:0] A_RX   = BASE + 16'd1;
  localparam logic [15:0] A_ST   = BASE + 16'd2;
  localparam logic [15:0] A_BAUD = BASE + 16'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   vectors = 0;
  int   errors = 0;
  int   n_cur = 4;
  logic [7:0] mon_q[$];

  mm_uart_if bus ();

  mm_uart_periph #(.BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] st_word(input bit txf, txe, rxa, ovr, busy, ferr);
    return {10'd0, ferr, busy, ovr, rxa, txe, txf};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.mm_we = 1'b1;
    @(negedge clk);
    bus.mm_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.mm_re = 1'b1;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.mm_re = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int n);
    @(negedge clk) rx = 1'b0;
    repeat (n - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (n - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop_bit;
    repeat (n - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic wait_tx_idle();
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 4000; i++) begin
      bus_read(A_ST, s);
      if (s[1] && !s[4]) break;
    end
    check("tx_idle", {14'd0, s[4], s[1]}, 16'h0001);
  endtask

  // Line monitor: decode 8N1 frames on tx by sampling mid-bit.
  initial begin : mon
    logic [7:0] mb;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (n_cur / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (n_cur) @(negedge clk);
          mb[i] = tx;
        end
        repeat (n_cur) @(negedge clk);
        if (tx === 1'b1) mon_q.push_back(mb);
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic [9:0]  fr;
    logic [7:0]  b;
    logic [7:0]  exp_tx[$];
    logic [7:0]  model_fifo[$];
    logic [7:0]  rx_model[$];
    bit          ovr;

    bus.addr = '0; bus.wdata = '0; bus.mm_we = 1'b0; bus.mm_re = 1'b0;
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_tx", {15'd0, tx}, 16'h0001);
    bus_read(A_ST, d);   check("reset_status", d, st_word(0, 1, 0, 0, 0, 0));
    bus_read(A_BAUD, d); check("reset_baud", d, 16'd434);
    bus_read(A_RX, d);   check("rx_empty_read", d, 16'h0000);
    bus_read(A_TX, d);   check("txdata_read", d, 16'h0000);
    bus_read(BASE + 16'd6, d); check("unselected_read", d, 16'h0000);
    bus_write(A_BAUD, 16'd4);
    bus_read(A_BAUD, d); check("baud_rw", d, 16'd4);

    // Exact waveform of 8'hA5 at N=4, with tx_busy watched on STATUS
    fr = {1'b1, 8'hA5, 1'b0};
    bus_write(A_TX, 16'h00A5);
    bus.addr = A_ST; bus.mm_re = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check("tx_wave", {15'd0, tx}, {15'd0, fr[k / 4]});
      check("tx_busy", {15'd0, bus.rdata[4]}, 16'h0001);
    end
    @(negedge clk);
    #1;
    check("tx_idle_line", {15'd0, tx}, 16'h0001);
    check("tx_busy_end", {15'd0, bus.rdata[4]}, 16'h0000);
    bus.mm_re = 1'b0;
    repeat (4) @(negedge clk);

    // Random divisor, random bytes, decoded by the line monitor
    n_cur = $urandom_range(3, 7);
    bus_write(A_BAUD, 16'(n_cur));
    mon_q.delete();
    exp_tx.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      bus_write(A_TX, {8'($urandom), b});
    end
    wait_tx_idle();
    repeat (4) @(negedge clk);
    check("rand_tx_count", 16'(mon_q.size()), 16'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < mon_q.size(); i++)
      check("rand_tx_byte", {8'h00, mon_q[i]}, {8'h00, exp_tx[i]});
    n_cur = 4;
    bus_write(A_BAUD, 16'd4);

    // Overfill the TX FIFO while the first byte is on the line
    mon_q.delete();
    exp_tx.delete();
    model_fifo.delete();
    b = 8'($urandom);
    exp_tx.push_back(b);
    bus_write(A_TX, {8'h00, b});
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, {8'h00, b});
      if (model_fifo.size() < 8) model_fifo.push_back(b);
    end
    bus_read(A_ST, d);
    check("tx_full_status", d, st_word(model_fifo.size() == 8, model_fifo.size() == 0, 0, 0, 1, 0));
    foreach (model_fifo[i]) exp_tx.push_back(model_fifo[i]);
    wait_tx_idle();
    repeat (4) @(negedge clk);
    check("burst_tx_count", 16'(mon_q.size()), 16'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < mon_q.size(); i++)
      check("burst_tx_byte", {8'h00, mon_q[i]}, {8'h00, exp_tx[i]});

    // Single RX frame
    send_rx(8'h3C, 1'b1, 4);
    bus_read(A_ST, d); check("rx_avail", d, st_word(0, 1, 1, 0, 0, 0));
    bus_read(A_RX, d); check("rx_data", d, 16'h003C);
    bus_read(A_ST, d); check("rx_popped", d, st_word(0, 1, 0, 0, 0, 0));

    // Overrun: five frames into a four-deep FIFO
    rx_model.delete();
    ovr = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 4);
      if (rx_model.size() < 4) rx_model.push_back(b);
      else ovr = 1;
    end
    bus_read(A_ST, d); check("overrun_status", d, st_word(0, 1, rx_model.size() > 0, ovr, 0, 0));
    while (rx_model.size() > 0) begin
      bus_read(A_RX, d);
      check("rx_order", d, {8'h00, rx_model.pop_front()});
    end
    bus_read(A_ST, d); check("overrun_held", d, st_word(0, 1, 0, ovr, 0, 0));
    bus_write(A_ST, 16'h0008);
    bus_read(A_ST, d); check("overrun_clear", d, st_word(0, 1, 0, 0, 0, 0));
    bus_read(A_RX, d); check("rx_drained", d, 16'h0000);

    // Framing error and start-bit glitch
    send_rx(8'($urandom), 1'b0, 4);
    bus_read(A_ST, d); check("frame_err", d, st_word(0, 1, 0, 0, 0, 1));
    bus_write(A_ST, 16'h0020);
    bus_read(A_ST, d); check("frame_err_clear", d, st_word(0, 1, 0, 0, 0, 0));
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_ST, d); check("glitch_ignored", d, st_word(0, 1, 0, 0, 0, 0));

    // Reset in the middle of an all-zero byte
    send_rx(8'($urandom), 1'b1, 4);
    bus_write(A_TX, 16'h0000);
    repeat (12) @(negedge clk);
    check("tx_low_mid_byte", {15'd0, tx}, 16'h0000);
    #2 rst_n = 1'b0;
    #1 check("tx_async_reset", {15'd0, tx}, 16'h0001);
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_ST, d);   check("post_reset_status", d, 16'h0002);
    bus_read(A_BAUD, d); check("post_reset_baud", d, 16'd434);
    bus_read(A_RX, d);   check("post_reset_rx", d, 16'h0000);
    repeat (60) @(negedge clk);

`ifdef MM_UART_LOOPBACK_EN
    bus_write(A_BAUD, 16'd4);
    bus_write(A_ST, 16'h8000);
    bus_read(A_ST, d); check("loopback_status", d, 16'h8002);
    rx = 1'b0;
    bus_write(A_TX, 16'h005A);
    wait_tx_idle();
    repeat (8) @(negedge clk);
    bus_read(A_RX, d); check("loopback_echo", d, 16'h005A);
    rx = 1'b1;
`else
    bus_write(A_ST, 16'h8000);
    bus_read(A_ST, d); check("no_loopback_bit", d, 16'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
